// File: rtl/tluh_pkg.sv
// TL-UH shared widths, burst constant, and arbiter owner-FIFO entry plus beat-count helpers.
// Latency: none (package).
// Backpressure: n/a.
package tluh_pkg;

    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_DBW = TL_DW / 8;
    localparam int TL_SZW = 2;

    // log2 size that makes a 64-bit access span two 32-bit beats
    localparam logic [TL_SZW-1:0] TL_BURST_SZ = 2'd3;

    // Owner id field is sized for up to 16 hosts; arbiters use the low HIDW bits.
    localparam int TL_ARB_IDW = 4;

    typedef struct packed {
        logic [TL_ARB_IDW-1:0] id;
        logic [1:0]            rsp_beats;
    } tluh_arb_entry_t;

    // Writes and atomics carry data, so a burst-sized one needs two request beats.
    function automatic logic [1:0] req_beats(input logic [TL_SZW-1:0] size,
                                             input logic              we,
                                             input logic [2:0]        op);
        return (size == TL_BURST_SZ && (we || op != 3'd0)) ? 2'd2 : 2'd1;
    endfunction

    // Reads and atomics return data, so a burst-sized one returns two response beats.
    function automatic logic [1:0] rsp_beats(input logic [TL_SZW-1:0] size,
                                             input logic              we,
                                             input logic [2:0]        op);
        return (size == TL_BURST_SZ && (!we || op != 3'd0)) ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/tluh_owner_fifo.sv
// Small synchronous FIFO holding the owner of each outstanding request, head visible combinationally.
// Latency: push visible at head one cycle later; pop takes effect at the next edge.
// Backpressure: push ignored when full, pop ignored when empty; caller must honour full/empty.
// Ports: clk_i/rst_i, push/push_dat, pop, full, empty, count, head_dat.
module tluh_owner_fifo #(
    parameter  int DEPTH = 2,
    parameter  int W     = 8,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic [W-1:0]  head_dat
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full     = (int'(count) == DEPTH);
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign head_dat = mem[rd_ptr];

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tluh_host_arbiter.sv
// Round-robin arbiter sharing one TL-UH adapter request port; keeps 2-beat bursts atomic, routes responses in order.
// Latency: request and response paths are combinational (zero cycles); owner bookkeeping updates on the edge.
// Backpressure: no new request while MAX_REQS are outstanding; a locked host that drops req stalls the port.
// Ports: h_* per-host request/grant/response, m_* adapter side, unexp_rsp_o flags a response with no owner.
module tluh_host_arbiter
    import tluh_pkg::*;
#(
    parameter int N_HOSTS  = 4,
    parameter int MAX_REQS = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [N_HOSTS-1:0]          h_req_i,
    output logic [N_HOSTS-1:0]          h_gnt_o,
    input  logic [N_HOSTS*TL_AW-1:0]    h_addr_i,
    input  logic [N_HOSTS-1:0]          h_we_i,
    input  logic [N_HOSTS*TL_DW-1:0]    h_wdata_i,
    input  logic [N_HOSTS*TL_DBW-1:0]   h_be_i,
    input  logic [N_HOSTS*TL_SZW-1:0]   h_size_i,
    input  logic [N_HOSTS*3-1:0]        h_op_i,
    input  logic [N_HOSTS-1:0]          h_arith_i,
    output logic [N_HOSTS-1:0]          h_valid_o,
    output logic [TL_DW-1:0]            h_rdata_o,
    output logic [N_HOSTS-1:0]          h_err_o,
    output logic                        m_req_o,
    output logic [TL_AW-1:0]            m_addr_o,
    output logic                        m_we_o,
    output logic [TL_DW-1:0]            m_wdata_o,
    output logic [TL_DBW-1:0]           m_be_o,
    output logic [TL_SZW-1:0]           m_size_o,
    output logic [2:0]                  m_op_o,
    output logic                        m_arith_o,
    input  logic                        m_gnt_i,
    input  logic                        m_valid_i,
    input  logic [TL_DW-1:0]            m_rdata_i,
    input  logic                        m_err_i,
    output logic                        unexp_rsp_o
);

    localparam int HIDW = $clog2(N_HOSTS);
    localparam int EW   = $bits(tluh_arb_entry_t);
    localparam int CW   = $clog2(MAX_REQS + 1);

    typedef enum logic {ST_IDLE, ST_BURST} state_e;

    state_e          state_q, state_d;
    logic [HIDW-1:0] rr_q, rr_d, lock_q, lock_d;
    logic [HIDW-1:0] search_idx, sel;
    logic [1:0]      beat_cnt_q;

    logic [TL_AW-1:0]  sel_addr;
    logic              sel_we;
    logic [TL_DW-1:0]  sel_wdata;
    logic [TL_DBW-1:0] sel_be;
    logic [TL_SZW-1:0] sel_size;
    logic [2:0]        sel_op;
    logic              sel_arith;

    logic            allowed, req_ok, hs, push;
    logic            fifo_full, fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [EW-1:0]   head_raw;
    tluh_arb_entry_t head, push_entry;
    logic            rsp_hit, last_beat, pop;

    function automatic logic [HIDW-1:0] inc_mod(input logic [HIDW-1:0] v);
        return (int'(v) == N_HOSTS - 1) ? '0 : v + HIDW'(1);
    endfunction

    // Cyclic search from rr_q: scan offsets high to low so the nearest requester wins.
    always_comb begin
        int idx;
        search_idx = rr_q;
        idx        = 0;
        for (int i = N_HOSTS - 1; i >= 0; i--) begin
            idx = (int'(rr_q) + i) % N_HOSTS;
            if (h_req_i[HIDW'(idx)]) search_idx = HIDW'(idx);
        end
    end

    assign sel = (state_q == ST_BURST) ? lock_q : search_idx;

    assign sel_addr  = h_addr_i[sel*TL_AW +: TL_AW];
    assign sel_we    = h_we_i[sel];
    assign sel_wdata = h_wdata_i[sel*TL_DW +: TL_DW];
    assign sel_be    = h_be_i[sel*TL_DBW +: TL_DBW];
    assign sel_size  = h_size_i[sel*TL_SZW +: TL_SZW];
    assign sel_op    = h_op_i[sel*3 +: 3];
    assign sel_arith = h_arith_i[sel];

    // The second beat of a burst is always allowed: its entry was pushed on beat one.
    // Full blocks a new request even if a pop is happening this cycle.
    assign allowed = (state_q == ST_BURST) || (int'(fifo_count) < MAX_REQS);
    assign req_ok  = h_req_i[sel] & allowed & ~rst_i;
    assign hs      = req_ok & m_gnt_i;

    // Outputs are forced to zero while reset is held.
    assign m_req_o   = req_ok;
    assign m_addr_o  = rst_i ? '0 : sel_addr;
    assign m_we_o    = ~rst_i & sel_we;
    assign m_wdata_o = rst_i ? '0 : sel_wdata;
    assign m_be_o    = rst_i ? '0 : sel_be;
    assign m_size_o  = rst_i ? '0 : sel_size;
    assign m_op_o    = rst_i ? '0 : sel_op;
    assign m_arith_o = ~rst_i & sel_arith;

    always_comb begin
        h_gnt_o = '0;
        if (hs) h_gnt_o[sel] = 1'b1;
    end

    always_comb begin
        state_d            = state_q;
        rr_d               = rr_q;
        lock_d             = lock_q;
        push               = 1'b0;
        push_entry.id      = TL_ARB_IDW'(sel);
        push_entry.rsp_beats = rsp_beats(sel_size, sel_we, sel_op);
        case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    push = 1'b1;
                    if (req_beats(sel_size, sel_we, sel_op) == 2'd2) begin
                        state_d = ST_BURST;
                        lock_d  = sel;
                    end else begin
                        rr_d = inc_mod(sel);
                    end
                end
            end
            ST_BURST: begin
                if (hs) begin
                    rr_d    = inc_mod(lock_q);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            rr_q    <= '0;
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            lock_q  <= lock_d;
        end
    end

    tluh_owner_fifo #(
        .DEPTH (MAX_REQS),
        .W     (EW)
    ) u_owner_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push     (push),
        .push_dat (push_entry),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .head_dat (head_raw)
    );

    assign head = tluh_arb_entry_t'(head_raw);

    assign rsp_hit   = m_valid_i & ~fifo_empty & ~rst_i;
    assign last_beat = ((beat_cnt_q + 2'd1) == head.rsp_beats);
    assign pop       = rsp_hit & last_beat;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)        beat_cnt_q <= '0;
        else if (rsp_hit) beat_cnt_q <= last_beat ? 2'd0 : beat_cnt_q + 2'd1;
    end

    always_comb begin
        h_valid_o = '0;
        h_err_o   = '0;
        for (int i = 0; i < N_HOSTS; i++) begin
            if (rsp_hit && head.id == TL_ARB_IDW'(i)) begin
                h_valid_o[i] = 1'b1;
                h_err_o[i]   = m_err_i;
            end
        end
    end

    assign h_rdata_o   = rst_i ? '0 : m_rdata_i;
    assign unexp_rsp_o = m_valid_i & fifo_empty & ~rst_i;

    // The allowed gate must keep pushes away from a full FIFO.
    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push && fifo_full));

endmodule

// File: tb/tb_tluh_host_arbiter.sv
// Randomized bench for tluh_host_arbiter checked against a queue-based reference model.
// Latency: compares combinational outputs mid-cycle, advances the model at each rising edge.
// Backpressure: adapter grant and response valid are randomized, including responses with nothing outstanding.
module tb_tluh_host_arbiter;
    import tluh_pkg::*;

    localparam int NH   = 4;
    localparam int MAXR = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NH-1:0]           h_req, h_we, h_arith;
    logic [NH*TL_AW-1:0]     h_addr;
    logic [NH*TL_DW-1:0]     h_wdata;
    logic [NH*TL_DBW-1:0]    h_be;
    logic [NH*TL_SZW-1:0]    h_size;
    logic [NH*3-1:0]         h_op;
    logic [NH-1:0]           h_gnt, h_valid, h_err;
    logic [TL_DW-1:0]        h_rdata;
    logic                    m_req, m_we, m_arith, m_gnt, m_valid, m_err, unexp;
    logic [TL_AW-1:0]        m_addr;
    logic [TL_DW-1:0]        m_wdata, m_rdata;
    logic [TL_DBW-1:0]       m_be;
    logic [TL_SZW-1:0]       m_size;
    logic [2:0]              m_op;

    always #5 clk = ~clk;

    tluh_host_arbiter #(.N_HOSTS(NH), .MAX_REQS(MAXR)) dut (
        .clk_i(clk), .rst_i(rst),
        .h_req_i(h_req), .h_gnt_o(h_gnt), .h_addr_i(h_addr), .h_we_i(h_we),
        .h_wdata_i(h_wdata), .h_be_i(h_be), .h_size_i(h_size), .h_op_i(h_op),
        .h_arith_i(h_arith), .h_valid_o(h_valid), .h_rdata_o(h_rdata), .h_err_o(h_err),
        .m_req_o(m_req), .m_addr_o(m_addr), .m_we_o(m_we), .m_wdata_o(m_wdata),
        .m_be_o(m_be), .m_size_o(m_size), .m_op_o(m_op), .m_arith_o(m_arith),
        .m_gnt_i(m_gnt), .m_valid_i(m_valid), .m_rdata_i(m_rdata), .m_err_i(m_err),
        .unexp_rsp_o(unexp)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: owner queue, lock holder (-1 when free), RR pointer, response beats seen.
    typedef struct { int id; int beats; } own_t;
    own_t q[$];
    int   ptr    = 0;
    int   locked = -1;
    int   bcnt   = 0;

    task automatic model_reset();
        q.delete();
        ptr    = 0;
        locked = -1;
        bcnt   = 0;
    endtask

    // Checks the current cycle's outputs, advances the model, then moves to 1 ns after the next edge.
    task automatic cycle();
        int sel, rqb, rsb, sz, we, op;
        bit mreq;
        own_t e;
        #3;
        if (rst) begin
            chk("rst_m_req", m_req, 0);
            chk("rst_h_gnt", h_gnt, 0);
            chk("rst_h_valid", h_valid, 0);
            chk("rst_h_err", h_err, 0);
            chk("rst_unexp", unexp, 0);
            chk("rst_m_addr", m_addr, 0);
            chk("rst_h_rdata", h_rdata, 0);
            model_reset();
        end else begin
            sel = -1;
            if (locked >= 0) sel = locked;
            else begin
                for (int k = 0; k < NH; k++) begin
                    if (h_req[(ptr + k) % NH]) begin
                        sel = (ptr + k) % NH;
                        break;
                    end
                end
            end
            mreq = (sel >= 0) && h_req[sel] && (locked >= 0 || q.size() < MAXR);
            chk("m_req", m_req, mreq);
            chk("h_gnt", h_gnt, (mreq && m_gnt) ? (64'd1 << sel) : 64'd0);
            if (mreq) begin
                chk("m_addr", m_addr, h_addr[sel*TL_AW +: TL_AW]);
                chk("m_we", m_we, h_we[sel]);
                chk("m_wdata", m_wdata, h_wdata[sel*TL_DW +: TL_DW]);
                chk("m_be", m_be, h_be[sel*TL_DBW +: TL_DBW]);
                chk("m_size", m_size, h_size[sel*TL_SZW +: TL_SZW]);
                chk("m_op", m_op, h_op[sel*3 +: 3]);
                chk("m_arith", m_arith, h_arith[sel]);
            end
            chk("h_rdata", h_rdata, m_rdata);
            if (m_valid && q.size() == 0) begin
                chk("unexp", unexp, 1);
                chk("h_valid", h_valid, 0);
                chk("h_err", h_err, 0);
            end else if (m_valid) begin
                chk("unexp", unexp, 0);
                chk("h_valid", h_valid, 64'd1 << q[0].id);
                chk("h_err", h_err, m_err ? (64'd1 << q[0].id) : 64'd0);
            end else begin
                chk("unexp", unexp, 0);
                chk("h_valid", h_valid, 0);
                chk("h_err", h_err, 0);
            end
            // Pop uses the queue as it stood this cycle, before any push.
            if (m_valid && q.size() > 0) begin
                bcnt++;
                if (bcnt == q[0].beats) begin
                    void'(q.pop_front());
                    bcnt = 0;
                end
            end
            if (mreq && m_gnt) begin
                if (locked >= 0) begin
                    ptr    = (locked + 1) % NH;
                    locked = -1;
                end else begin
                    sz  = int'(h_size[sel*TL_SZW +: TL_SZW]);
                    we  = int'(h_we[sel]);
                    op  = int'(h_op[sel*3 +: 3]);
                    rqb = (sz == 3 && (we != 0 || op != 0)) ? 2 : 1;
                    rsb = (sz == 3 && (we == 0 || op != 0)) ? 2 : 1;
                    e.id    = sel;
                    e.beats = rsb;
                    q.push_back(e);
                    if (rqb == 2) locked = sel;
                    else          ptr = (sel + 1) % NH;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        h_req = '0; h_we = '0; h_arith = '0; h_addr = '0; h_wdata = '0;
        h_be = '0; h_size = '0; h_op = '0;
        m_gnt = 1'b0; m_valid = 1'b0; m_err = 1'b0; m_rdata = '0;
    endtask

    task automatic rand_inputs();
        h_req   = NH'($urandom);
        h_we    = NH'($urandom);
        h_arith = NH'($urandom);
        for (int i = 0; i < NH; i++) begin
            h_addr[i*TL_AW +: TL_AW]    = $urandom;
            h_wdata[i*TL_DW +: TL_DW]   = $urandom;
            h_be[i*TL_DBW +: TL_DBW]    = TL_DBW'($urandom);
            h_size[i*TL_SZW +: TL_SZW]  = TL_SZW'($urandom_range(0, 3));
            h_op[i*3 +: 3]              = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
        end
        m_gnt   = ($urandom_range(0, 9) < 7);
        m_valid = ($urandom_range(0, 3) == 0);
        m_err   = $urandom_range(0, 1) == 1;
        m_rdata = $urandom;
        rst     = ($urandom_range(0, 199) == 0);
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;

        // Two single-beat Gets from host0 and host2, then their responses in order.
        h_size[0*TL_SZW +: TL_SZW] = 2'd2;
        h_size[2*TL_SZW +: TL_SZW] = 2'd2;
        h_req = 4'b0101; m_gnt = 1'b1;
        #2 chk("t1_gnt_first", h_gnt, 4'b0001);
        cycle();
        h_req = 4'b0100;
        #2 chk("t1_gnt_second", h_gnt, 4'b0100);
        cycle();
        h_req = 4'b0000; m_valid = 1'b1; m_rdata = 32'hA5A5_0001;
        #2 chk("t1_valid_first", h_valid, 4'b0001);
        cycle();
        m_rdata = 32'hA5A5_0002;
        #2 chk("t1_valid_second", h_valid, 4'b0100);
        cycle();

        // Response with nothing outstanding.
        #2 chk("t5_unexp", unexp, 1'b1);
        chk("t5_valid", h_valid, 4'b0000);
        cycle();
        m_valid = 1'b0;
        #2 chk("t5_unexp_clear", unexp, 1'b0);
        cycle();

        // Reset in the middle of a PutFull burst with its entry pending.
        clear_inputs();
        h_size[1*TL_SZW +: TL_SZW] = 2'd3;
        h_we[1] = 1'b1;
        h_req = 4'b0010; m_gnt = 1'b1;
        cycle();
        h_req = 4'b1010;
        rst = 1'b1;
        #2 chk("t6_rst_mreq", m_req, 1'b0);
        chk("t6_rst_gnt", h_gnt, 4'b0000);
        cycle();
        rst = 1'b0; h_req = 4'b0000; m_valid = 1'b1;
        #2 chk("t6_post_unexp", unexp, 1'b1);
        cycle();
        m_valid = 1'b0;
        cycle();

        for (int n = 0; n < 4000; n++) begin
            rand_inputs();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
